// File: rtl/fiber_access_mem_arbiter.sv
// fiber_access_mem_arbiter
//   Shares one single-port SRAM between a write requester and a read requester.
//   At most one access is granted per cycle. Read data comes back through a
//   small return FIFO. A read is only granted when the FIFO has room for its
//   data, so the consumer can stall without any data being lost.
//
// Ports
//   clk_i, flush_i          clock and synchronous active-high reset
//   clk_en_i                0 = freeze all state, issue no grants
//   wr_prio_mode_i          0 = round-robin, 1 = write priority with starvation guard
//   wr_req_i/wr_addr_i/wr_data_i/wr_ready_o        write request channel
//   rd_req_i/rd_addr_i/rd_ready_o                  read request channel
//   rd_data_o/rd_data_valid_o/rd_data_ready_i      read return FIFO head
//   addr_to_mem_o/data_to_mem_o/wen_to_mem_o/ren_to_mem_o/data_from_mem_i  SRAM side
module fiber_access_mem_arbiter #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 64,
  parameter int RD_FIFO_DEPTH = 2,
  parameter int MAX_WAIT      = 8
) (
  input  logic              clk_i,
  input  logic              flush_i,
  input  logic              clk_en_i,
  input  logic              wr_prio_mode_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_data_valid_o,
  input  logic              rd_data_ready_i,
  output logic [ADDR_W-1:0] addr_to_mem_o,
  output logic [DATA_W-1:0] data_to_mem_o,
  output logic              wen_to_mem_o,
  output logic              ren_to_mem_o,
  input  logic [DATA_W-1:0] data_from_mem_i
);

  localparam int PTR_W  = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  grant_e              last_grant_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                inflight_q;
  logic [CNT_W-1:0]    fifo_cnt_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [DATA_W-1:0]   fifo_mem [RD_FIFO_DEPTH];

  logic                active;
  logic [SUM_W-1:0]    credit_used;
  logic                rd_ok;
  logic                gnt_wr;
  logic                gnt_rd;
  logic                push;
  logic                pop;

  // Flush also blocks grants so nothing reaches the SRAM during reset.
  assign active      = clk_en_i & ~flush_i;
  // A read occupies a FIFO slot from grant onwards, so in-flight reads count as used credit.
  assign credit_used = SUM_W'(fifo_cnt_q) + SUM_W'(inflight_q);
  assign rd_ok       = rd_req_i & (credit_used < SUM_W'(RD_FIFO_DEPTH));

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (active) begin
      if (wr_req_i && rd_ok) begin
        if (wr_prio_mode_i) begin
          if (wait_cnt_q == WAIT_W'(MAX_WAIT)) gnt_rd = 1'b1;
          else                                 gnt_wr = 1'b1;
        end else begin
          if (last_grant_q == GRANT_RD) gnt_wr = 1'b1;
          else                          gnt_rd = 1'b1;
        end
      end else if (wr_req_i) begin
        gnt_wr = 1'b1;
      end else if (rd_ok) begin
        gnt_rd = 1'b1;
      end
    end
  end

  assign wr_ready_o    = gnt_wr;
  assign wen_to_mem_o  = gnt_wr;
  assign rd_ready_o    = gnt_rd;
  assign ren_to_mem_o  = gnt_rd;
  assign addr_to_mem_o = gnt_wr ? wr_addr_i : (gnt_rd ? rd_addr_i : '0);
  assign data_to_mem_o = gnt_wr ? wr_data_i : '0;

  assign rd_data_valid_o = (fifo_cnt_q != '0);
  assign rd_data_o       = rd_data_valid_o ? fifo_mem[rd_ptr_q] : '0;

  // SRAM data is valid the cycle after ren, which is exactly when inflight_q is set.
  assign push = inflight_q;
  assign pop  = rd_data_valid_o & rd_data_ready_i;

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      last_grant_q <= GRANT_RD;
      wait_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else if (clk_en_i) begin
      inflight_q <= gnt_rd;

      if (gnt_wr)      last_grant_q <= GRANT_WR;
      else if (gnt_rd) last_grant_q <= GRANT_RD;

      if (gnt_rd)
        wait_cnt_q <= '0;
      else if (rd_req_i && (wait_cnt_q != WAIT_W'(MAX_WAIT)))
        wait_cnt_q <= wait_cnt_q + 1'b1;

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      // The credit check in rd_ok must make a push into a full FIFO impossible.
      assert (!(push && !pop) || (fifo_cnt_q < CNT_W'(RD_FIFO_DEPTH)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i && clk_en_i && push) fifo_mem[wr_ptr_q] <= data_from_mem_i;
  end

endmodule

// File: tb/tb_fiber_access_mem_arbiter.sv
module tb_fiber_access_mem_arbiter;

  logic        clk = 1'b0;
  logic        flush, clk_en, mode;
  logic        wr_req, wr_ready;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rd_req, rd_ready;
  logic [8:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_data_valid, rd_data_ready;
  logic [8:0]  addr_to_mem;
  logic [63:0] data_to_mem;
  logic        wen_to_mem, ren_to_mem;
  logic [63:0] data_from_mem;

  logic [63:0] sram [512];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fiber_access_mem_arbiter dut (
    .clk_i(clk), .flush_i(flush), .clk_en_i(clk_en), .wr_prio_mode_i(mode),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
    .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid), .rd_data_ready_i(rd_data_ready),
    .addr_to_mem_o(addr_to_mem), .data_to_mem_o(data_to_mem),
    .wen_to_mem_o(wen_to_mem), .ren_to_mem_o(ren_to_mem), .data_from_mem_i(data_from_mem)
  );

  // Behavioural single-port SRAM with one cycle read latency.
  always @(posedge clk) begin
    if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
    if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
  end

  typedef struct {
    logic       fl, en, md, wr;
    logic [8:0] wa;
    logic       rr;
    logic [8:0] ra;
    logic       rdy;
    logic       e_wr, e_rd;
    logic [8:0] e_addr;
    logic       e_dv;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(logic fl, logic en, logic md, logic wr, logic [8:0] wa,
                              logic rr, logic [8:0] ra, logic rdy,
                              logic e_wr, logic e_rd, logic [8:0] e_addr, logic e_dv);
    vec_t v;
    v.fl = fl; v.en = en; v.md = md; v.wr = wr; v.wa = wa; v.rr = rr; v.ra = ra;
    v.rdy = rdy; v.e_wr = e_wr; v.e_rd = e_rd; v.e_addr = e_addr; v.e_dv = e_dv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic fl, input logic en, input logic md,
                     input logic wr, input logic [8:0] wa, input logic [63:0] wd,
                     input logic rr, input logic [8:0] ra, input logic rdy);
    flush = fl; clk_en = en; mode = md; wr_req = wr; wr_addr = wa; wr_data = wd;
    rd_req = rr; rd_addr = ra; rd_data_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             fl en md wr wa   rr ra   rdy  ewr erd eaddr edv
    vt[0]  = mk(1, 1, 0, 1, 9'd7, 1, 9'd8, 1,  0, 0, 9'd0,  0);  // outputs quiet during flush
    vt[1]  = mk(0, 1, 0, 0, 9'd0, 0, 9'd0, 1,  0, 0, 9'd0,  0);
    vt[2]  = mk(0, 1, 0, 1, 9'd0, 0, 9'd0, 1,  1, 0, 9'd0,  0);  // write burst 0..3
    vt[3]  = mk(0, 1, 0, 1, 9'd1, 0, 9'd0, 1,  1, 0, 9'd1,  0);
    vt[4]  = mk(0, 1, 0, 1, 9'd2, 0, 9'd0, 1,  1, 0, 9'd2,  0);
    vt[5]  = mk(0, 1, 0, 1, 9'd3, 0, 9'd0, 1,  1, 0, 9'd3,  0);
    vt[6]  = mk(1, 1, 0, 0, 9'd0, 0, 9'd0, 1,  0, 0, 9'd0,  0);  // flush, then round-robin
    vt[7]  = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 1, 0, 9'd10, 0);
    vt[8]  = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 0, 1, 9'd20, 0);
    vt[9]  = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 1, 0, 9'd10, 0);
    vt[10] = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 0, 1, 9'd20, 1);
    vt[11] = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 1, 0, 9'd10, 0);
    vt[12] = mk(0, 0, 0, 1, 9'd10, 1, 9'd20, 1, 0, 0, 9'd0,  1);  // clk_en low: frozen
    vt[13] = mk(0, 0, 0, 1, 9'd10, 1, 9'd20, 1, 0, 0, 9'd0,  1);
    vt[14] = mk(0, 0, 0, 1, 9'd10, 1, 9'd20, 1, 0, 0, 9'd0,  1);
    vt[15] = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 0, 1, 9'd20, 1);  // resumes with read
    vt[16] = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 1, 0, 9'd10, 0);
    vt[17] = mk(0, 1, 0, 0, 9'd0, 0, 9'd0, 1,  0, 0, 9'd0,  1);
    vt[18] = mk(0, 1, 0, 0, 9'd0, 1, 9'd20, 1, 0, 1, 9'd20, 0);   // read, then flush
    vt[19] = mk(1, 1, 0, 1, 9'd10, 1, 9'd20, 1, 0, 0, 9'd0,  0);
    vt[20] = mk(0, 1, 0, 1, 9'd10, 1, 9'd20, 1, 1, 0, 9'd10, 0);
    vt[21] = mk(0, 1, 0, 0, 9'd0, 0, 9'd0, 1,  0, 0, 9'd0,  0);
    vt[22] = mk(0, 1, 0, 0, 9'd0, 0, 9'd0, 1,  0, 0, 9'd0,  0);

    drv(vt[0].fl, vt[0].en, vt[0].md, vt[0].wr, vt[0].wa, 64'h1234, vt[0].rr, vt[0].ra, vt[0].rdy);

    for (int i = 0; i < 23; i++) begin
      drv(vt[i].fl, vt[i].en, vt[i].md, vt[i].wr, vt[i].wa, 64'h1000 + 64'(i),
          vt[i].rr, vt[i].ra, vt[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d wr_ready", i), 64'(wr_ready), 64'(vt[i].e_wr));
      chk($sformatf("vec%0d wen", i), 64'(wen_to_mem), 64'(vt[i].e_wr));
      chk($sformatf("vec%0d rd_ready", i), 64'(rd_ready), 64'(vt[i].e_rd));
      chk($sformatf("vec%0d ren", i), 64'(ren_to_mem), 64'(vt[i].e_rd));
      chk($sformatf("vec%0d addr", i), 64'(addr_to_mem), 64'(vt[i].e_addr));
      chk($sformatf("vec%0d rd_valid", i), 64'(rd_data_valid), 64'(vt[i].e_dv));
      next_cycle();
    end

    // Write-then-read to the same address with a stalled consumer.
    drv(1, 1, 0, 0, 9'd0, 64'h0, 0, 9'd0, 0);
    next_cycle();
    drv(0, 1, 0, 1, 9'd5, 64'hDEAD, 0, 9'd0, 0);
    @(negedge clk);
    chk("t3 wr_ready", 64'(wr_ready), 64'd1);
    chk("t3 data_to_mem", data_to_mem, 64'hDEAD);
    chk("t3 wr addr", 64'(addr_to_mem), 64'd5);
    next_cycle();
    drv(0, 1, 0, 0, 9'd0, 64'h0, 1, 9'd5, 0);
    @(negedge clk);
    chk("t3 rd1 ready", 64'(rd_ready), 64'd1);
    chk("t3 rd1 addr", 64'(addr_to_mem), 64'd5);
    next_cycle();
    @(negedge clk);
    chk("t3 rd2 ready", 64'(rd_ready), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("t3 rd3 blocked", 64'(rd_ready), 64'd0);
    chk("t3 valid", 64'(rd_data_valid), 64'd1);
    chk("t3 data", rd_data, 64'hDEAD);
    next_cycle();
    @(negedge clk);
    chk("t3 rd3 still blocked", 64'(rd_ready), 64'd0);
    chk("t3 data held", rd_data, 64'hDEAD);
    next_cycle();
    rd_data_ready = 1'b1;
    @(negedge clk);
    chk("t3 pop blocked", 64'(rd_ready), 64'd0);
    chk("t3 pop data", rd_data, 64'hDEAD);
    next_cycle();
    rd_data_ready = 1'b0;
    @(negedge clk);
    chk("t3 rd3 granted", 64'(rd_ready), 64'd1);
    chk("t3 second data", rd_data, 64'hDEAD);
    next_cycle();
    drv(0, 1, 0, 0, 9'd0, 64'h0, 0, 9'd0, 1);
    for (int i = 0; i < 4; i++) next_cycle();
    @(negedge clk);
    chk("t3 drained", 64'(rd_data_valid), 64'd0);
    next_cycle();

    // Write priority with starvation guard: one read every MAX_WAIT+1 cycles.
    drv(1, 1, 1, 0, 9'd0, 64'h0, 0, 9'd0, 1);
    next_cycle();
    drv(0, 1, 1, 1, 9'd33, 64'hBEEF, 1, 9'd44, 1);
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      chk($sformatf("t4 c%0d rd_ready", i), 64'(rd_ready), 64'((i % 9) == 8));
      chk($sformatf("t4 c%0d wr_ready", i), 64'(wr_ready), 64'((i % 9) != 8));
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
